forth_bus_controller: RTL and testbench

Memory-mapped slave for the Forth CPU's data bus. It serves `get`/`set` cycles with a data RAM and a small I/O page, and holds the interval timer and external-interrupt pending logic. It drives the CPU's two-bit `interrupt` input and observes `interrupt_ack`. It sits directly downstream of the CPU's `mem_*` port.

---
 rtl/forth_bus_pkg.sv | 28 ++
 rtl/forth_bus_controller_if.sv | 29 ++
 rtl/forth_timer.sv | 49 ++++
 rtl/forth_bus_controller.sv | 174 +++++++++++++++++
 tb/tb_forth_bus_controller.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/forth_bus_pkg.sv
// forth_bus_pkg
// Shared constants and types for the Forth CPU data-bus slave:
//   - I/O page address map (IO_BASE .. ADDR_LASTACK)
//   - bus FSM state enum
//   - TCTRL / ISTAT bit positions
package forth_bus_pkg;

  localparam logic [15:0] IO_BASE      = 16'hFF00;
  localparam logic [15:0] ADDR_TCOUNT  = 16'hFF00;
  localparam logic [15:0] ADDR_TRELOAD = 16'hFF01;
  localparam logic [15:0] ADDR_TCTRL   = 16'hFF02;
  localparam logic [15:0] ADDR_ISTAT   = 16'hFF03;
  localparam logic [15:0] ADDR_GPIO    = 16'hFF04;
  localparam logic [15:0] ADDR_LASTACK = 16'hFF05;

  localparam int TCTRL_EN    = 0;
  localparam int TCTRL_IE    = 1;
  localparam int ISTAT_TIMER = 0;
  localparam int ISTAT_EXT   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } bus_state_t;

endpackage

// File: rtl/forth_bus_controller_if.sv
// forth_bus_controller_if
// CPU data-bus bundle between the Forth CPU (master) and the bus controller (slave).
//   mem_address / mem_wdata / mem_valid / mem_nwr : master -> slave
//   mem_rdata / mem_ready                         : slave -> master
// Handshake: the master raises mem_valid with address, data and nwr stable and
// keeps them stable until it sees mem_ready. mem_ready is a one-cycle pulse that
// completes exactly one transfer; mem_rdata is valid in that cycle. The master
// must drop mem_valid before the slave will accept another request, so a valid
// held past mem_ready never starts a second transfer.
interface forth_bus_controller_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_valid;
  logic             mem_nwr;
  logic             mem_ready;

  modport master (
    output mem_address, mem_wdata, mem_valid, mem_nwr,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_address, mem_wdata, mem_valid, mem_nwr,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/forth_timer.sv
// forth_timer
// Interval timer: prescaler, down-counter with reload, and a tick-at-zero pulse.
//   clk, nreset   : clock, async active-low reset
//   i_en          : timer enable (TCTRL.EN)
//   i_start       : EN 0->1 write; loads the count and clears the prescaler
//   i_reload      : reload value (TRELOAD)
//   o_count       : current count (TCOUNT)
//   o_zero_tick   : high in the cycle whose closing edge reloads from zero
module forth_timer #(
  parameter int WIDTH         = 16,
  parameter int PRESCALE_BITS = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             i_en,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_reload,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero_tick
);

  logic             w_tick;
  logic [WIDTH-1:0] r_count;

  generate
    if (PRESCALE_BITS == 0) begin : g_nopre
      assign w_tick = i_en;
    end else begin : g_pre
      logic [PRESCALE_BITS-1:0] r_pre;
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)      r_pre <= '0;
        else if (i_start) r_pre <= '0;
        else if (i_en)    r_pre <= r_pre + 1'b1;
      end
      // One tick per full prescaler wrap.
      assign w_tick = i_en & (&r_pre);
    end
  endgenerate

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)      r_count <= '0;
    else if (i_start) r_count <= i_reload;
    else if (w_tick)  r_count <= (r_count == '0) ? i_reload : r_count - 1'b1;
  end

  assign o_count     = r_count;
  assign o_zero_tick = w_tick & (r_count == '0);

endmodule

// File: rtl/forth_bus_controller.sv
// forth_bus_controller
// Memory-mapped slave on the Forth CPU data bus: word RAM below 0xFF00, I/O page
// at 0xFF00-0xFF05 (timer, interrupt status, GPIO, last ack), interrupt outputs.
//   clk, nreset   : clock, async active-low reset
//   bus           : forth_bus_controller_if slave modport (mem_* signals)
//   interrupt     : bit0 timer (gated by IE), bit1 external
//   interrupt_ack : interrupt number last taken by the CPU
//   ext_irq       : asynchronous external interrupt request
//   gpio_out      : GPIO register
//   o_dbg_state   : bus FSM state
// Macro FORTH_BUS_EXT_IRQ_EN enables the external interrupt path; without it
// ext_irq is ignored and ISTAT bit1 / interrupt[1] are tied to 0.
module forth_bus_controller
  import forth_bus_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int RAM_BITS      = 8,
  parameter int WAIT_STATES   = 0,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                    clk,
  input  logic                    nreset,
  forth_bus_controller_if.slave   bus,
  output logic [1:0]              interrupt,
  input  logic [1:0]              interrupt_ack,
  input  logic                    ext_irq,
  output logic [WIDTH-1:0]        gpio_out,
  output bus_state_t              o_dbg_state
);

  bus_state_t       r_state, w_next;
  logic [3:0]       r_wait;
  logic [WIDTH-1:0] r_addr, r_wdata, r_rdata, w_rd_data;
  logic             r_nwr;

  logic [WIDTH-1:0] r_treload, r_gpio, w_tcount;
  logic [1:0]       r_tctrl, r_istat, r_lastack;
  logic [WIDTH-1:0] r_ram [2**RAM_BITS];

  logic w_is_ram, w_wr, w_wr_ram, w_rd_ack;
  logic w_wr_treload, w_wr_tctrl, w_wr_istat, w_wr_gpio;
  logic w_tstart, w_zero_tick, w_clr_timer, w_ext_next;

  // ---------------- bus FSM ----------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.mem_valid) w_next = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
      // Counter holds the cycles still to wait; leave when this one is the last.
      ST_WAIT: if (r_wait <= 4'd1) w_next = ST_ACK;
      ST_ACK:  w_next = ST_DONE;
      ST_DONE: if (!bus.mem_valid) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_nwr   <= 1'b1;
      r_wait  <= '0;
    end else if (r_state == ST_IDLE && bus.mem_valid) begin
      r_addr  <= bus.mem_address;
      r_wdata <= bus.mem_wdata;
      r_nwr   <= bus.mem_nwr;
      r_wait  <= 4'(WAIT_STATES);
    end else if (r_state == ST_WAIT) begin
      r_wait  <= r_wait - 1'b1;
    end
  end

  assign o_dbg_state   = r_state;
  assign bus.mem_ready = (r_state == ST_ACK);

  // ---------------- decode ----------------
  assign w_is_ram     = (r_addr < WIDTH'(IO_BASE));
  assign w_wr         = (r_state == ST_ACK) & ~r_nwr;
  assign w_rd_ack     = (r_state == ST_ACK) & r_nwr;
  assign w_wr_ram     = w_wr & w_is_ram;
  assign w_wr_treload = w_wr & (r_addr == WIDTH'(ADDR_TRELOAD));
  assign w_wr_tctrl   = w_wr & (r_addr == WIDTH'(ADDR_TCTRL));
  assign w_wr_istat   = w_wr & (r_addr == WIDTH'(ADDR_ISTAT));
  assign w_wr_gpio    = w_wr & (r_addr == WIDTH'(ADDR_GPIO));
  assign w_tstart     = w_wr_tctrl & r_wdata[TCTRL_EN] & ~r_tctrl[TCTRL_EN];
  assign w_clr_timer  = w_wr_istat & r_wdata[ISTAT_TIMER];

  always_comb begin
    w_rd_data = '0;
    if (w_is_ram) begin
      w_rd_data = r_ram[r_addr[RAM_BITS-1:0]];
    end else begin
      case (r_addr)
        WIDTH'(ADDR_TCOUNT):  w_rd_data = w_tcount;
        WIDTH'(ADDR_TRELOAD): w_rd_data = r_treload;
        WIDTH'(ADDR_TCTRL):   w_rd_data = {{(WIDTH-2){1'b0}}, r_tctrl};
        WIDTH'(ADDR_ISTAT):   w_rd_data = {{(WIDTH-2){1'b0}}, r_istat};
        WIDTH'(ADDR_GPIO):    w_rd_data = r_gpio;
        WIDTH'(ADDR_LASTACK): w_rd_data = {{(WIDTH-2){1'b0}}, r_lastack};
        default:              w_rd_data = '0;
      endcase
    end
  end

  // Live data during the ACK of a read, otherwise the last value read.
  assign bus.mem_rdata = w_rd_ack ? w_rd_data : r_rdata;

  always_ff @(posedge clk) begin
    if (w_wr_ram) r_ram[r_addr[RAM_BITS-1:0]] <= r_wdata;
  end

  // ---------------- timer ----------------
  forth_timer #(
    .WIDTH         (WIDTH),
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_timer (
    .clk         (clk),
    .nreset      (nreset),
    .i_en        (r_tctrl[TCTRL_EN]),
    .i_start     (w_tstart),
    .i_reload    (r_treload),
    .o_count     (w_tcount),
    .o_zero_tick (w_zero_tick)
  );

  // ---------------- external interrupt ----------------
`ifdef FORTH_BUS_EXT_IRQ_EN
  logic [2:0] r_sync;
  logic       w_ext_rise, w_clr_ext;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_sync <= '0;
    else         r_sync <= {r_sync[1:0], ext_irq};
  end
  // r_sync[1] is the synchronized level; r_sync[2] is its previous value.
  assign w_ext_rise = r_sync[1] & ~r_sync[2];
  assign w_clr_ext  = w_wr_istat & r_wdata[ISTAT_EXT];
  assign w_ext_next = (r_istat[ISTAT_EXT] & ~w_clr_ext) | w_ext_rise;
`else
  logic w_unused_ext_irq;
  assign w_unused_ext_irq = ext_irq;
  assign w_ext_next       = 1'b0;
`endif

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_treload <= '0;
      r_tctrl   <= '0;
      r_gpio    <= '0;
      r_lastack <= '0;
      r_istat   <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_wr_treload) r_treload <= r_wdata;
      if (w_wr_tctrl)   r_tctrl   <= r_wdata[1:0];
      if (w_wr_gpio)    r_gpio    <= r_wdata;
      if (interrupt_ack != 2'b00) r_lastack <= interrupt_ack;
      if (w_rd_ack)     r_rdata   <= w_rd_data;
      // A set event in the same cycle as a W1C wins.
      r_istat[ISTAT_TIMER] <= (r_istat[ISTAT_TIMER] & ~w_clr_timer) | w_zero_tick;
      r_istat[ISTAT_EXT]   <= w_ext_next;
    end
  end

  assign interrupt[ISTAT_TIMER] = r_istat[ISTAT_TIMER] & r_tctrl[TCTRL_IE];
  assign interrupt[ISTAT_EXT]   = r_istat[ISTAT_EXT];
  assign gpio_out               = r_gpio;

endmodule

// File: tb/tb_forth_bus_controller.sv
// Testbench for forth_bus_controller (WAIT_STATES=2, PRESCALE_BITS=0, RAM_BITS=8).
module tb_forth_bus_controller;
  import forth_bus_pkg::*;

  localparam int W  = 16;
  localparam int RB = 8;
  localparam int WS = 2;
  localparam int PB = 0;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             nreset = 1'b0;
  logic [1:0]       interrupt;
  logic [1:0]       interrupt_ack = 2'b00;
  logic             ext_irq = 1'b0;
  logic [W-1:0]     gpio_out;
  bus_state_t       dbg_state;

  forth_bus_controller_if #(.WIDTH(W)) bus ();

  forth_bus_controller #(
    .WIDTH(W), .RAM_BITS(RB), .WAIT_STATES(WS), .PRESCALE_BITS(PB)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .bus           (bus),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .ext_irq       (ext_irq),
    .gpio_out      (gpio_out),
    .o_dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int last_commit = 0;

  // Scoreboard: reference RAM contents and expected read queue.
  logic [W-1:0] ram_model [int];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] addr_q [$];

  // ---------------- driver ----------------
  // Called #1 after a posedge. Returns the read data and the number of edges
  // from the first sampling edge to the edge after which mem_ready is seen.
  task automatic xfer(input logic nwr, input logic [W-1:0] addr,
                      input logic [W-1:0] wdata,
                      output logic [W-1:0] rdata, output int lat);
    bus.mem_valid   = 1'b1;
    bus.mem_nwr     = nwr;
    bus.mem_address = addr;
    bus.mem_wdata   = wdata;
    lat   = -1;
    rdata = '0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ready === 1'b1) begin
        lat   = i;
        rdata = bus.mem_rdata;
      end
    end
    bus.mem_valid = 1'b0;
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL xfer_timeout addr=%h got=no_ready want=ready", addr);
    end
    @(posedge clk); #1;
    last_commit = cyc;  // edge that closed the ACK cycle
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] rd;
    int lat;
    logic [W-1:0] regs [5];
    regs[0] = ADDR_TCOUNT; regs[1] = ADDR_TRELOAD; regs[2] = ADDR_TCTRL;
    regs[3] = ADDR_ISTAT;  regs[4] = ADDR_LASTACK;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b want=0", bus.mem_ready); end
    vectors++; if (bus.mem_rdata !== 16'h0) begin miscompares++; $display("FAIL rst_rdata got=%h want=0000", bus.mem_rdata); end
    vectors++; if (interrupt !== 2'b00) begin miscompares++; $display("FAIL rst_interrupt got=%b want=00", interrupt); end
    vectors++; if (gpio_out !== 16'h0) begin miscompares++; $display("FAIL rst_gpio got=%h want=0000", gpio_out); end
    vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL rst_state got=%0d want=IDLE", dbg_state); end
    nreset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      xfer(1'b1, regs[i], 16'h0, rd, lat);
      vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL rst_reg_%h got=%h want=0000", regs[i], rd); end
    end
  endtask

  task automatic test_ram();
    logic [W-1:0] rd, a, d, held;
    int lat;
    xfer(1'b0, 16'h0010, 16'h1234, rd, lat);
    vectors++; if (lat !== WS + 1) begin miscompares++; $display("FAIL ram_wr_latency got=%0d want=%0d", lat, WS + 1); end
    xfer(1'b1, 16'h0010, 16'h0, rd, lat);
    vectors++; if (lat !== WS + 1) begin miscompares++; $display("FAIL ram_rd_latency got=%0d want=%0d", lat, WS + 1); end
    vectors++; if (rd !== 16'h1234) begin miscompares++; $display("FAIL ram_roundtrip got=%h want=1234", rd); end
    xfer(1'b0, 16'h0110, 16'hBEEF, rd, lat);
    ram_model[16'h10] = 16'hBEEF;
    xfer(1'b1, 16'h0010, 16'h0, rd, lat);
    vectors++; if (rd !== 16'hBEEF) begin miscompares++; $display("FAIL ram_alias got=%h want=beef", rd); end
    // Random writes anywhere below the I/O page, read back through another alias.
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom_range(0, 16'hFEFF));
      d = W'($urandom);
      xfer(1'b0, a, d, rd, lat);
      ram_model[int'(a % (1 << RB))] = d;
      addr_q.push_back(a);
    end
    while (addr_q.size() > 0) begin
      a = addr_q.pop_front();
      exp_q.push_back(ram_model[int'(a % (1 << RB))]);
      a = W'($urandom_range(0, 8'hFE)) * 256 + (a % (1 << RB));
      xfer(1'b1, a, 16'h0, rd, lat);
      d = exp_q.pop_front();
      vectors++; if (rd !== d) begin miscompares++; $display("FAIL ram_random addr=%h got=%h want=%h", a, rd, d); end
    end
    held = rd;
    // Unmapped I/O addresses complete and read zero.
    xfer(1'b1, 16'hFF20, 16'h0, rd, lat);
    vectors++; if (lat !== WS + 1) begin miscompares++; $display("FAIL unmapped_latency got=%0d want=%0d", lat, WS + 1); end
    vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL unmapped_ff20 got=%h want=0000", rd); end
    a = W'($urandom_range(16'hFF06, 16'hFFFF));
    xfer(1'b0, a, 16'hA5A5, rd, lat);
    xfer(1'b1, a, 16'h0, rd, lat);
    vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL unmapped_rand addr=%h got=%h want=0000", a, rd); end
    // Read data is held across a following write.
    xfer(1'b1, 16'h0010, 16'h0, held, lat);
    xfer(1'b0, 16'h0020, 16'h5555, rd, lat);
    vectors++; if (bus.mem_rdata !== held) begin miscompares++; $display("FAIL rdata_hold got=%h want=%h", bus.mem_rdata, held); end
  endtask

  task automatic test_held_valid();
    logic [W-1:0] rd;
    int lat, extra;
    bus.mem_valid = 1'b1; bus.mem_nwr = 1'b1; bus.mem_address = 16'h0010; bus.mem_wdata = 16'h0;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ready === 1'b1) lat = i;
    end
    vectors++; if (lat !== WS + 1) begin miscompares++; $display("FAIL held_first_ack got=%0d want=%0d", lat, WS + 1); end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ready === 1'b1) extra++;
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL held_extra_acks got=%0d want=0", extra); end
    bus.mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    xfer(1'b1, 16'h0010, 16'h0, rd, lat);
    vectors++; if (lat !== WS + 1) begin miscompares++; $display("FAIL held_next_latency got=%0d want=%0d", lat, WS + 1); end
    vectors++; if (rd !== 16'hBEEF) begin miscompares++; $display("FAIL held_next_data got=%h want=beef", rd); end
  endtask

  task automatic test_io();
    logic [W-1:0] rd, g, t;
    int lat;
    g = W'($urandom) | 16'h0001;
    xfer(1'b0, ADDR_GPIO, g, rd, lat);
    vectors++; if (gpio_out !== g) begin miscompares++; $display("FAIL gpio_out got=%h want=%h", gpio_out, g); end
    xfer(1'b1, ADDR_GPIO, 16'h0, rd, lat);
    vectors++; if (rd !== g) begin miscompares++; $display("FAIL gpio_read got=%h want=%h", rd, g); end
    t = W'($urandom);
    xfer(1'b0, ADDR_TRELOAD, t, rd, lat);
    xfer(1'b1, ADDR_TRELOAD, 16'h0, rd, lat);
    vectors++; if (rd !== t) begin miscompares++; $display("FAIL treload_read got=%h want=%h", rd, t); end
    xfer(1'b0, ADDR_TCTRL, 16'hFFFC, rd, lat);
    xfer(1'b1, ADDR_TCTRL, 16'h0, rd, lat);
    vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL tctrl_mask got=%h want=0000", rd); end
    xfer(1'b0, ADDR_TCOUNT, 16'h5A5A, rd, lat);
    xfer(1'b1, ADDR_TCOUNT, 16'h0, rd, lat);
    vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL tcount_ro got=%h want=0000", rd); end
  endtask

  task automatic test_timer();
    logic [W-1:0] rd;
    int lat, e, c1, c2, period, d;
    logic exp_i0;
    period = (3 + 1) * (1 << PB);
    xfer(1'b0, ADDR_TRELOAD, 16'd3, rd, lat);
    xfer(1'b0, ADDR_TCTRL, 16'd3, rd, lat);
    e  = last_commit;
    c1 = e + period + 2;   // W1C landing between zero ticks
    c2 = e + 3 * period;   // W1C landing on a zero tick
    exp_i0 = 1'b0;
    while (cyc < e + 4 * period) begin
      if (cyc + 1 == c1 - WS - 1 || cyc + 1 == c2 - WS - 1) begin
        bus.mem_valid = 1'b1; bus.mem_nwr = 1'b0;
        bus.mem_address = ADDR_ISTAT; bus.mem_wdata = 16'h0001;
      end
      if (cyc + 1 == c1 || cyc + 1 == c2) bus.mem_valid = 1'b0;
      @(posedge clk); #1;
      d = cyc - e;
      if (d % period == 0) exp_i0 = 1'b1;
      else if (cyc == c1 || cyc == c2) exp_i0 = 1'b0;
      vectors++;
      if (interrupt[0] !== exp_i0) begin
        miscompares++;
        $display("FAIL timer_irq edge=E+%0d got=%b want=%b", d, interrupt[0], exp_i0);
      end
    end
    xfer(1'b0, ADDR_TCTRL, 16'h0, rd, lat);
    xfer(1'b0, ADDR_ISTAT, 16'h0003, rd, lat);
    xfer(1'b1, ADDR_ISTAT, 16'h0, rd, lat);
    vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL timer_cleared got=%h want=0000", rd); end
  endtask

  task automatic test_ext_irq();
    logic [W-1:0] rd;
    logic [1:0] ack;
    int lat, rise;
    ext_irq = 1'b1;
    rise = -1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) ext_irq = 1'b0;
      if (rise < 0 && interrupt[1] === 1'b1) rise = i;
    end
`ifdef FORTH_BUS_EXT_IRQ_EN
    vectors++; if (rise < 2 || rise > 3) begin miscompares++; $display("FAIL ext_latency got=%0d want=2..3", rise); end
`else
    vectors++; if (rise !== -1) begin miscompares++; $display("FAIL ext_disabled got=%0d want=never", rise); end
`endif
    ack = 2'($urandom_range(1, 3));
    interrupt_ack = ack;
    @(posedge clk); #1;
    interrupt_ack = 2'b00;
    xfer(1'b1, ADDR_LASTACK, 16'h0, rd, lat);
    vectors++; if (rd !== {14'h0, ack}) begin miscompares++; $display("FAIL lastack_rand got=%h want=%h", rd, ack); end
    interrupt_ack = 2'd2;
    @(posedge clk); #1;
    interrupt_ack = 2'b00;
    xfer(1'b1, ADDR_LASTACK, 16'h0, rd, lat);
    vectors++; if (rd !== 16'h2) begin miscompares++; $display("FAIL lastack_2 got=%h want=0002", rd); end
    xfer(1'b1, ADDR_ISTAT, 16'h0, rd, lat);
`ifdef FORTH_BUS_EXT_IRQ_EN
    vectors++; if (rd !== 16'h2) begin miscompares++; $display("FAIL ext_pending got=%h want=0002", rd); end
    vectors++; if (interrupt[1] !== 1'b1) begin miscompares++; $display("FAIL ext_irq_held got=%b want=1", interrupt[1]); end
`else
    vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL ext_pending_off got=%h want=0000", rd); end
`endif
    xfer(1'b0, ADDR_ISTAT, 16'h0002, rd, lat);
    xfer(1'b1, ADDR_ISTAT, 16'h0, rd, lat);
    vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL ext_w1c got=%h want=0000", rd); end
    vectors++; if (interrupt !== 2'b00) begin miscompares++; $display("FAIL ext_irq_cleared got=%b want=00", interrupt); end
  endtask

  task automatic test_reset_mid();
    int readies;
    vectors++; if (gpio_out === 16'h0) begin miscompares++; $display("FAIL mid_pre_gpio got=%h want=nonzero", gpio_out); end
    bus.mem_valid = 1'b1; bus.mem_nwr = 1'b0;
    bus.mem_address = ADDR_GPIO; bus.mem_wdata = W'($urandom) | 16'h0100;
    @(posedge clk); #1;
    vectors++; if (dbg_state !== ST_WAIT) begin miscompares++; $display("FAIL mid_in_wait got=%0d want=WAIT", dbg_state); end
    nreset = 1'b0;
    #1;
    vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL mid_state got=%0d want=IDLE", dbg_state); end
    vectors++; if (gpio_out !== 16'h0) begin miscompares++; $display("FAIL mid_gpio got=%h want=0000", gpio_out); end
    bus.mem_valid = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    readies = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ready === 1'b1) readies++;
    end
    vectors++; if (readies !== 0) begin miscompares++; $display("FAIL mid_no_ready got=%0d want=0", readies); end
    vectors++; if (gpio_out !== 16'h0) begin miscompares++; $display("FAIL mid_gpio_after got=%h want=0000", gpio_out); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.mem_valid = 1'b0; bus.mem_nwr = 1'b1;
    bus.mem_address = '0; bus.mem_wdata = '0;
    test_reset();
    test_ram();
    test_held_valid();
    test_io();
    test_timer();
    test_ext_irq();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
